// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-type enum, FSM states and the alignment/type legality check for the data memory arbiter
package dmem_pkg;
  typedef enum logic [2:0] {
    MT_LB  = 3'b000,
    MT_LH  = 3'b001,
    MT_LW  = 3'b010,
    MT_LBU = 3'b011,
    MT_LHU = 3'b100
  } mem_type_e;
  typedef enum logic {ST_IDLE, ST_RESP} state_e;
  function automatic logic is_legal(input logic [2:0] t, input logic we, input logic [1:0] a);
    return (t == MT_LB)  ? 1'b1 :
           (t == MT_LH)  ? !a[0] :
           (t == MT_LW)  ? (a == 2'b00) :
           (t == MT_LBU) ? !we :
           (t == MT_LHU) ? (!we && !a[0]) : 1'b0;
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr when en; ports req/ptr/en in, one-hot gnt and idx out
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  int p;
  always_comb begin
    gnt = '0;
    idx = '0;
    p = 0;
    for (int k = N - 1; k >= 0; k--) begin
      p = (int'(ptr) + k) % N;
      if (en && req[p]) begin
        gnt = '0;
        gnt[p] = 1'b1;
        idx = IW'(p);
      end
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of one data memory among NREQ valid/ready requesters; req_* in / req_ready out, registered rsp_* out, mem_* driven in the grant cycle
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0][2:0]     req_type,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [DW-1:0]            rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_rd_en,
  output logic                     mem_wr_en,
  output logic [2:0]               mem_type,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata
);
  localparam int IW = $clog2(NREQ);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, g_q, g_d, w_idx;
  logic [NREQ-1:0] w_gnt;
  logic [DW-1:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic rsp_done, grant_en, granted, legal;
  assign rsp_done = (state_q == ST_RESP) && rsp_ready[g_q];
  assign grant_en = (state_q == ST_IDLE) || rsp_done;
  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (grant_en),
    .gnt (w_gnt),
    .idx (w_idx)
  );
  assign granted = |w_gnt;
  assign legal = is_legal(req_type[w_idx], req_we[w_idx], req_addr[w_idx][1:0]);
  always_comb begin
    req_ready = w_gnt;
    mem_rd_en = granted && legal && !req_we[w_idx];
    mem_wr_en = granted && legal && req_we[w_idx];
    mem_type  = granted ? req_type[w_idx] : '0;
    mem_addr  = granted ? req_addr[w_idx] : '0;
    mem_wdata = granted ? req_wdata[w_idx] : '0;
    rsp_valid = '0;
    rsp_valid[g_q] = (state_q == ST_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    state_d = granted ? ST_RESP : rsp_done ? ST_IDLE : state_q;
    g_d     = granted ? w_idx : g_q;
    ptr_d   = granted ? ((w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1) : ptr_q;
    rdata_d = granted ? (mem_rd_en ? mem_rdata : '0) : rsp_done ? '0 : rdata_q;
    err_d   = granted ? !legal : rsp_done ? 1'b0 : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, reset corner case and randomized traffic checked against a transaction-level model
module tb_dmem_arbiter;
  localparam int NREQ = 2, AW = 32, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready, req_we = '0, rsp_valid, rsp_ready = '0;
  logic [NREQ-1:0][2:0] req_type = '0;
  logic [NREQ-1:0][AW-1:0] req_addr = '0;
  logic [NREQ-1:0][DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic rsp_err, mem_rd_en, mem_wr_en;
  logic [2:0] mem_type;
  logic [AW-1:0] mem_addr;
  always #5 clk = ~clk;
  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  function automatic logic [7:0] init_byte(input int i);
    return (i == 8) ? 8'hEF : (i == 9) ? 8'hBE : (i == 10) ? 8'hAD : (i == 11) ? 8'hDE : 8'(i) ^ 8'h5A;
  endfunction
  logic [7:0] env_mem [256];
  logic [7:0] ea, eb;
  logic [15:0] eh;
  logic [31:0] ew;
  always_comb begin
    ea = {mem_addr[7:2], 2'b00};
    ew = {env_mem[ea + 8'd3], env_mem[ea + 8'd2], env_mem[ea + 8'd1], env_mem[ea]};
    eh = mem_addr[1] ? ew[31:16] : ew[15:0];
    eb = ew[8 * mem_addr[1:0] +: 8];
    mem_rdata = (mem_type == 3'd0) ? {{24{eb[7]}}, eb} :
                (mem_type == 3'd1) ? {{16{eh[15]}}, eh} :
                (mem_type == 3'd3) ? {24'd0, eb} :
                (mem_type == 3'd4) ? {16'd0, eh} : ew;
  end
  always @(posedge clk)
    if (rst) for (int i = 0; i < 256; i++) env_mem[i] <= init_byte(i);
    else if (mem_wr_en)
      for (int i = 0; i < 4; i++)
        if (i < ((mem_type == 3'd2) ? 4 : (mem_type == 3'd1) ? 2 : 1))
          env_mem[mem_addr[7:0] + 8'(i)] <= mem_wdata[8*i +: 8];
  int vectors = 0, miscompares = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  logic [7:0] m_mem [256];
  bit pend, perr;
  int pg, mptr, last_w;
  logic [31:0] prdata;
  task automatic model_reset();
    pend = 0; perr = 0; pg = 0; mptr = 0; prdata = '0; last_w = -1;
    for (int i = 0; i < 256; i++) m_mem[i] = init_byte(i);
  endtask
  function automatic int size_of(input int t);
    return (t == 2) ? 4 : (t == 1 || t == 4) ? 2 : 1;
  endfunction
  function automatic bit m_legal(input bit we, input int t, input int a);
    if (t > 4 || (we && t > 2)) return 0;
    return (a % size_of(t)) == 0;
  endfunction
  function automatic logic [31:0] m_load(input int t, input int a);
    longint v = 0;
    for (int i = size_of(t) - 1; i >= 0; i--) v = v * 256 + longint'(m_mem[a + i]);
    if (t == 0 && v >= 128) v -= 256;
    if (t == 1 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction
  task automatic tick();
    int w, p, t, a;
    bit en, lg, we;
    #1;
    en = !pend || rsp_ready[pg];
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      p = (mptr + k) % NREQ;
      if (en && req_valid[p] && w < 0) w = p;
    end
    we = 0; t = 0; a = 0; lg = 0;
    if (w >= 0) begin
      we = req_we[w]; t = int'(req_type[w]); a = int'(req_addr[w][7:0]); lg = m_legal(we, t, a);
    end
    chk("req_ready", 32'(req_ready), (w >= 0) ? 32'(1 << w) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), pend ? 32'(1 << pg) : 32'd0);
    if (pend) begin
      chk("rsp_rdata", rsp_rdata, prdata);
      chk("rsp_err", 32'(rsp_err), 32'(perr));
    end
    chk("mem_rd_en", 32'(mem_rd_en), 32'(lg && !we));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(lg && we));
    chk("mem_addr", mem_addr, (w >= 0) ? req_addr[w] : 32'd0);
    chk("mem_type", 32'(mem_type), (w >= 0) ? 32'(req_type[w]) : 32'd0);
    chk("mem_wdata", mem_wdata, (w >= 0) ? req_wdata[w] : 32'd0);
    if (w >= 0) begin
      if (lg && we) for (int i = 0; i < size_of(t); i++) m_mem[a + i] = req_wdata[w][8*i +: 8];
      prdata = (lg && !we) ? m_load(t, a) : 32'd0;
      pend = 1; pg = w; perr = !lg; mptr = (w + 1) % NREQ;
    end else if (pend && en) pend = 0;
    last_w = w;
  endtask
  typedef struct {
    logic [1:0] v, we, rr, e_rdy, e_rv;
    logic [1:0][2:0] t;
    logic [1:0][7:0] a;
    logic [31:0] wd, e_rdata;
    logic e_rd, e_wr, e_err;
  } vec_t;
  function automatic vec_t mk(input logic [1:0] v, we, input logic [5:0] t, input logic [15:0] a,
                              input logic [31:0] wd, input logic [1:0] rr, e_rdy, input logic e_rd, e_wr,
                              input logic [1:0] e_rv, input logic [31:0] e_rdata, input logic e_err);
    vec_t r;
    r.v = v; r.we = we; r.t = t; r.a = a; r.wd = wd; r.rr = rr; r.e_rdy = e_rdy;
    r.e_rd = e_rd; r.e_wr = e_wr; r.e_rv = e_rv; r.e_rdata = e_rdata; r.e_err = e_err;
    return r;
  endfunction
  task automatic new_req(input int p);
    req_valid[p] = ($urandom_range(0, 3) != 0);
    req_we[p] = 1'($urandom_range(0, 1));
    req_type[p] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    req_addr[p] = 32'($urandom_range(0, 63));
    req_wdata[p] = $urandom;
  endtask
  vec_t tbl[$];
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_mem_en", 32'({mem_rd_en, mem_wr_en}), 32'd0);
    chk("reset_mem_bus", mem_addr | mem_wdata | 32'(mem_type), 32'd0);
    rst = 1'b0;
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 6'o02, 16'h0008, 32'h0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b10, 2'b10, 6'o20, 16'h1000, 32'hAA, 2'b11, 2'b10, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b10, 2'b00, 6'o30, 16'h1000, 32'h0, 2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 32'hAA, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b11, 2'b01, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b11, 2'b10, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b11, 2'b01, 1'b1, 1'b0, 2'b10, 32'hAA, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b11, 2'b10, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 32'hAA, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'b11, 2'b00, 6'o22, 16'h1008, 32'h0, 2'b01, 2'b10, 1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 32'hAA, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b01, 2'b00, 6'o02, 16'h0006, 32'h0, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b10, 2'b10, 6'o10, 16'h0300, 32'h1234, 2'b11, 2'b10, 1'b0, 1'b0, 2'b01, 32'h0, 1'b1));
    tbl.push_back(mk(2'b01, 2'b01, 6'o03, 16'h0004, 32'h55, 2'b11, 2'b01, 1'b0, 1'b0, 2'b10, 32'h0, 1'b1));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 32'h0, 1'b1));
    tbl.push_back(mk(2'b10, 2'b00, 6'o50, 16'h0000, 32'h0, 2'b11, 2'b10, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 32'h0, 1'b1));
    tbl.push_back(mk(2'b01, 2'b00, 6'o01, 16'h000A, 32'h0, 2'b11, 2'b01, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 32'hFFFFDEAD, 1'b0));
    tbl.push_back(mk(2'b00, 2'b00, 6'o00, 16'h0000, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
    foreach (tbl[i]) begin
      req_valid = tbl[i].v; req_we = tbl[i].we; req_type = tbl[i].t; rsp_ready = tbl[i].rr;
      for (int p = 0; p < NREQ; p++) begin
        req_addr[p] = 32'(tbl[i].a[p]);
        req_wdata[p] = tbl[i].wd;
      end
      tick();
      chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_mem_rd_en", i), 32'(mem_rd_en), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_mem_wr_en", i), 32'(mem_wr_en), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv != 2'b00) begin
        chk($sformatf("tbl%0d_rsp_rdata", i), rsp_rdata, tbl[i].e_rdata);
        chk($sformatf("tbl%0d_rsp_err", i), 32'(rsp_err), 32'(tbl[i].e_err));
      end
      @(negedge clk);
    end
    req_valid = 2'b01; req_we = 2'b00; req_type = {3'd2, 3'd2}; req_addr[0] = 32'h8; req_addr[1] = 32'h10;
    rsp_ready = 2'b00;
    tick();
    @(negedge clk);
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    tick();
    chk("post_rst_priority", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    tick();
    chk("post_rst_rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    for (int p = 0; p < NREQ; p++) new_req(p);
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NREQ; p++) rsp_ready[p] = ($urandom_range(0, 3) != 0);
      tick();
      @(negedge clk);
      for (int p = 0; p < NREQ; p++) if (p == last_w || !req_valid[p]) new_req(p);
    end
    req_valid = '0; rsp_ready = '1;
    repeat (3) begin
      tick();
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory between NREQ requesters (port 0 = core load/store stage, port 1 = DMA/debug loader).
- Per-port valid/ready request and response channels, round-robin arbitration, alignment and type checking.
- Drives the memory's rd_en/wr_en/mem_type/addr/wdata and registers its asynchronous read data into a response.
- Sits between the pipeline memory stage and the data memory.

Parameters:
- NREQ, 2, number of requesters (2..4)
- AW, 32, address width
- DW, 32, data width (fixed 32; byte/half/word access)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  request valid per port
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_we  in  NREQ  1 = store, 0 = load
- req_type  in  NREQ x 3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
- req_addr  in  NREQ x AW  byte address
- req_wdata  in  NREQ x DW  store data
- rsp_valid  out  NREQ  response valid for port
- rsp_ready  in  NREQ  port consumes response
- rsp_rdata  out  DW  load data (stores return 0), shared bus qualified by rsp_valid
- rsp_err  out  1  misaligned or illegal access; no memory access performed
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_type  out  3  forwarded req_type
- mem_addr  out  AW  forwarded address
- mem_wdata  out  DW  forwarded store data
- mem_rdata  in  DW  combinational read data from memory

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rd_en=0, mem_wr_en=0, mem_type/addr/wdata=0. Round-robin pointer set so port 0 has highest priority. FSM = IDLE.
- FSM states: IDLE (no response pending) and RESP (one response held for port g).
- Grant condition: the FSM is in IDLE, or it is in RESP with rsp_ready[g]=1 in the same cycle (back-to-back).
- Grant selection: the first valid port at or after ptr, circularly. req_ready[w] is asserted combinationally that cycle.
- ptr is updated to w+1 (mod NREQ) on each grant only.
- Memory access happens in the grant cycle, with mem_* driven combinationally from the winner:
  - load: mem_rd_en=1
  - store: mem_wr_en=1 (memory writes at that clk edge)
  - mem_* are all 0 when no grant.
- Latency: the response is registered. rsp_valid[w]=1 and rsp_rdata=mem_rdata (load) or 0 (store), visible the cycle after the grant. The FSM goes to RESP with g=w.
- rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready[g].
- Consuming a response with no new grant returns the FSM to IDLE.
- Error rules:
  - lh/lhu with addr[0]=1 → error
  - lw with addr[1:0]≠0 → error
  - store with type 011/100 → error
  - types 101–111 → error
  - On error: request still accepted, no mem_rd_en/mem_wr_en, rsp_err=1, rsp_rdata=0 next cycle.
- Simultaneous requests from all ports in IDLE: exactly one grant. A port held valid continuously is granted within NREQ grants.
- A request is never dropped. A port must hold valid and all fields stable until req_ready.
- rsp_ready on a port not being answered is ignored.
- Reset asserted mid-transaction clears any pending response and ptr. An in-flight write at the reset edge is not guaranteed.

Decomposition:
- Shared package dmem_pkg:
  - mem_type_e enum (MT_LB, MT_LH, MT_LW, MT_LBU, MT_LHU)
  - function is_legal(type, we, addr[1:0])
- Sub-module rr_arbiter (param N): inputs req vector, ptr, enable; outputs one-hot grant and index. Purely combinational; ptr register stays in dmem_arbiter.

Test Plan:
- Single load: port0 lw addr 0x8, mem holds 0xDEADBEEF → req_ready[0] in cycle 0; rsp_valid[0]=1, rsp_rdata=0xDEADBEEF, rsp_err=0 in cycle 1.
- Contention: both ports valid every cycle, rsp_ready=1 → grants alternate 0,1,0,1; four accesses in 5 cycles, no port starved.
- Back-to-back: port1 sw 0x0000_00AA to 0x10, then lbu 0x10, rsp_ready held 1 → mem_wr_en cycle 0, mem_rd_en cycle 1, load response 0x000000AA cycle 2.
- Backpressure: rsp_ready[0]=0 for 3 cycles → rsp_valid/rsp_rdata stable, req_ready all 0, mem_* idle; resumes on ready.
- Misaligned: lw addr 0x6 and sh (type 001 write) addr 0x3 → no mem enables, rsp_err=1, rsp_rdata=0; sb type 011 write → rsp_err=1.
- Reset in RESP: assert rst asynchronously mid-cycle → rsp_valid=0 immediately; after release port0 has priority over port1.
